// File: rtl/traffic_sensor_conditioner_if.sv
// Request/grant bundle between the sensor conditioner (master) and the traffic light controller (slave).
// With TSC_SERVICE_COUNT_EN defined, the bundle also carries the per-approach service counters.
interface traffic_sensor_conditioner_if;
    logic        Sa;
    logic        Sb;
    logic        Ga;
    logic        Gb;
    logic        stall_a;
    logic        stall_b;
`ifdef TSC_SERVICE_COUNT_EN
    logic [15:0] served_a;
    logic [15:0] served_b;
`endif

    modport master (
        output Sa, Sb, stall_a, stall_b,
`ifdef TSC_SERVICE_COUNT_EN
        output served_a, served_b,
`endif
        input  Ga, Gb
    );

    modport slave (
        input  Sa, Sb, stall_a, stall_b,
`ifdef TSC_SERVICE_COUNT_EN
        input  served_a, served_b,
`endif
        output Ga, Gb
    );
endinterface

// File: rtl/traffic_sensor_conditioner.sv
// Detector front end: synchronise, debounce and latch per-approach requests until that approach's green.
// Optional macro TSC_SERVICE_COUNT_EN adds saturating 16-bit service counters per approach.
module tsc_channel #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        det,
    input  logic        grant,
    output logic        req,
    output logic        stall
`ifdef TSC_SERVICE_COUNT_EN
    ,
    output logic [15:0] served
`endif
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        SERVED = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_lvl;
    logic                   db;
    logic [DW-1:0]          db_cnt;
    logic [TW-1:0]          wait_cnt;
    state_t                 state;

    assign sync_lvl = sync_q[SYNC_STAGES-1];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], det};
        end
    end

    // A new level is accepted only after it has differed from db for DEBOUNCE_CYCLES straight edges.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            db     <= 1'b0;
            db_cnt <= '0;
        end else if (sync_lvl == db) begin
            db_cnt <= '0;
        end else if (db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
            db     <= sync_lvl;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            req      <= 1'b0;
            stall    <= 1'b0;
            wait_cnt <= '0;
`ifdef TSC_SERVICE_COUNT_EN
            served   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (db) begin
                        // A car arriving on an already-green approach needs no request.
                        if (grant) begin
                            state <= SERVED;
                        end else begin
                            state <= REQ;
                            req   <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (grant) begin
                        state    <= SERVED;
                        req      <= 1'b0;
                        stall    <= 1'b0;
                        wait_cnt <= '0;
`ifdef TSC_SERVICE_COUNT_EN
                        if (served != 16'hFFFF) served <= served + 16'd1;
`endif
                    end else if (wait_cnt != TW'(TIMEOUT_CYCLES)) begin
                        wait_cnt <= wait_cnt + 1'b1;
                        stall    <= (wait_cnt == TW'(TIMEOUT_CYCLES - 1));
                    end
                end
                SERVED: begin
                    // Re-arm only after the detector releases, so a parked car cannot re-request.
                    if (!db) state <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    req      <= 1'b0;
                    stall    <= 1'b0;
                    wait_cnt <= '0;
                end
            endcase
        end
    end
endmodule

module traffic_sensor_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic det_a,
    input  logic det_b,
    traffic_sensor_conditioner_if.master bus
);
    tsc_channel #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .TIMEOUT_CYCLES  (TIMEOUT_CYCLES)
    ) u_ch_a (
        .clk    (clk),
        .reset  (reset),
        .det    (det_a),
        .grant  (bus.Ga),
        .req    (bus.Sa),
        .stall  (bus.stall_a)
`ifdef TSC_SERVICE_COUNT_EN
        ,
        .served (bus.served_a)
`endif
    );

    tsc_channel #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .TIMEOUT_CYCLES  (TIMEOUT_CYCLES)
    ) u_ch_b (
        .clk    (clk),
        .reset  (reset),
        .det    (det_b),
        .grant  (bus.Gb),
        .req    (bus.Sb),
        .stall  (bus.stall_b)
`ifdef TSC_SERVICE_COUNT_EN
        ,
        .served (bus.served_b)
`endif
    );
endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Directed bench for traffic_sensor_conditioner with default parameters (latency 7 edges, timeout 32).
// Inputs are driven and outputs sampled 1 ns after each rising edge.
module tb_traffic_sensor_conditioner;
    logic clk = 1'b0;
    logic reset;
    logic det_a;
    logic det_b;
    int   n_checks = 0;
    int   n_fail   = 0;

    traffic_sensor_conditioner_if tsc_bus ();

    traffic_sensor_conditioner dut (
        .clk   (clk),
        .reset (reset),
        .det_a (det_a),
        .det_b (det_b),
        .bus   (tsc_bus.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset      = 1'b0;
        det_a      = 1'b1;
        det_b      = 1'b1;
        tsc_bus.Ga = 1'b0;
        tsc_bus.Gb = 1'b0;

        // Reset held with detectors active
        tick(3);
        check("rst_Sa", tsc_bus.Sa, 1'b0);
        check("rst_Sb", tsc_bus.Sb, 1'b0);
        check("rst_stall_a", tsc_bus.stall_a, 1'b0);
        check("rst_stall_b", tsc_bus.stall_b, 1'b0);
        reset = 1'b1;
        tick(6);
        check("lat6_Sa", tsc_bus.Sa, 1'b0);
        check("lat6_Sb", tsc_bus.Sb, 1'b0);
        tick(1);
        check("lat7_Sa", tsc_bus.Sa, 1'b1);
        check("lat7_Sb", tsc_bus.Sb, 1'b1);

        // Timeout on both channels, then service B only
        tick(31);
        check("to31_stall_b", tsc_bus.stall_b, 1'b0);
        check("to31_stall_a", tsc_bus.stall_a, 1'b0);
        tick(1);
        check("to32_stall_b", tsc_bus.stall_b, 1'b1);
        check("to32_stall_a", tsc_bus.stall_a, 1'b1);
        tick(5);
        check("to_sat_stall_b", tsc_bus.stall_b, 1'b1);
        check("to_sat_Sb", tsc_bus.Sb, 1'b1);
        tsc_bus.Gb = 1'b1;
        det_b      = 1'b0;
        tick(1);
        check("gb_Sb", tsc_bus.Sb, 1'b0);
        check("gb_stall_b", tsc_bus.stall_b, 1'b0);
        check("gb_stall_a_kept", tsc_bus.stall_a, 1'b1);
        tsc_bus.Gb = 1'b0;
        tick(10);
        check("b_idle_Sb", tsc_bus.Sb, 1'b0);

        // Mid-request asynchronous reset on A
        reset = 1'b0;
        #1;
        check("arst_Sa", tsc_bus.Sa, 1'b0);
        check("arst_stall_a", tsc_bus.stall_a, 1'b0);
        #2;
        reset = 1'b1;
        tick(6);
        check("rel6_Sa", tsc_bus.Sa, 1'b0);
        tick(1);
        check("rel7_Sa", tsc_bus.Sa, 1'b1);
        check("rel7_stall_a", tsc_bus.stall_a, 1'b0);

        // Handshake: drop on green, no re-request while car stays
        tsc_bus.Ga = 1'b1;
        tick(1);
        check("ga_Sa", tsc_bus.Sa, 1'b0);
        tsc_bus.Ga = 1'b0;
        tick(10);
        check("parked_Sa", tsc_bus.Sa, 1'b0);
        det_a = 1'b0;
        tick(8);
        det_a = 1'b1;
        tick(6);
        check("retrig6_Sa", tsc_bus.Sa, 1'b0);
        tick(1);
        check("retrig7_Sa", tsc_bus.Sa, 1'b1);
        tsc_bus.Ga = 1'b1;
        tick(1);
        tsc_bus.Ga = 1'b0;
        det_a      = 1'b0;
        tick(8);

        // Glitch rejection and latching of a minimal pulse
        det_a = 1'b1;
        tick(3);
        det_a = 1'b0;
        tick(20);
        check("glitch3_Sa", tsc_bus.Sa, 1'b0);
        det_a = 1'b1;
        tick(4);
        det_a = 1'b0;
        tick(2);
        check("pulse4_e6_Sa", tsc_bus.Sa, 1'b0);
        tick(1);
        check("pulse4_e7_Sa", tsc_bus.Sa, 1'b1);
        tick(20);
        check("pulse4_held_Sa", tsc_bus.Sa, 1'b1);
        tsc_bus.Ga = 1'b1;
        tick(1);
        check("pulse4_ga_Sa", tsc_bus.Sa, 1'b0);
        tsc_bus.Ga = 1'b0;
        tick(5);

        // Already green: no request, and none after green drops while car stays
        tsc_bus.Ga = 1'b1;
        det_a      = 1'b1;
        tick(7);
        check("green7_Sa", tsc_bus.Sa, 1'b0);
        tick(13);
        check("green20_Sa", tsc_bus.Sa, 1'b0);
        tsc_bus.Ga = 1'b0;
        tick(10);
        check("green_served_Sa", tsc_bus.Sa, 1'b0);
        det_a = 1'b0;
        tick(8);

`ifdef TSC_SERVICE_COUNT_EN
        check("served_a_3", tsc_bus.served_a, 32'd3);
        check("served_b_0", tsc_bus.served_b, 32'd0);
        reset = 1'b0;
        #1;
        check("served_a_rst", tsc_bus.served_a, 32'd0);
        #2;
        reset = 1'b1;
        tick(2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end
endmodule
